execute_stage: RTL and testbench

- Y86-64 pipeline Execute stage. It consumes the E pipeline register, which is fed from decode outputs (valA, valB, srcs and dsts).
- Produces e_valE, e_dstE and e_Cnd for the M register and for decode forwarding.
- Owns the condition-code register.
- Adds an iterative signed multiply (OPq ifun 4, mulq) that stalls the pipeline through a busy output.

---
 rtl/execute_stage.sv | 246 ++++++++++++++++++++++++
 tb/tb_execute_stage.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/execute_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : execute_stage                                                 |
// | Purpose  : Y86-64 Execute stage: ALU, condition codes, branch/cmov       |
// |            condition, and an iterative signed multiplier (mulq) that     |
// |            stalls the pipeline through e_busy_o.                         |
// | Options  : `define MUL_EARLY_EXIT_EN to finish a multiply as soon as the |
// |            remaining multiplier bits are all zero.                       |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module execute_stage #(
   parameter int MUL_BITS_PER_CYCLE = 2
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic [3:0]  E_stat_i,
   input  logic [3:0]  E_icode_i,
   input  logic [3:0]  E_ifun_i,
   input  logic [63:0] E_valC_i,
   input  logic [63:0] E_valA_i,
   input  logic [63:0] E_valB_i,
   input  logic [3:0]  E_dstE_i,
   input  logic [3:0]  E_dstM_i,
   input  logic [3:0]  m_stat_i,
   input  logic [3:0]  W_stat_i,
   output logic [63:0] e_valE_o,
   output logic [63:0] e_valA_o,
   output logic [3:0]  e_dstE_o,
   output logic [3:0]  e_dstM_o,
   output logic        e_Cnd_o,
   output logic        e_busy_o,
   output logic [2:0]  cc_o
);

   localparam logic [3:0] SAOK     = 4'd1;
   localparam logic [3:0] IRRMOVQ  = 4'h2;
   localparam logic [3:0] IIRMOVQ  = 4'h3;
   localparam logic [3:0] IRMMOVQ  = 4'h4;
   localparam logic [3:0] IMRMOVQ  = 4'h5;
   localparam logic [3:0] IOPQ     = 4'h6;
   localparam logic [3:0] ICALL    = 4'h8;
   localparam logic [3:0] IRET     = 4'h9;
   localparam logic [3:0] IPUSHQ   = 4'hA;
   localparam logic [3:0] IPOPQ    = 4'hB;
   localparam logic [3:0] ALUADD   = 4'd0;
   localparam logic [3:0] ALUSUB   = 4'd1;
   localparam logic [3:0] ALUAND   = 4'd2;
   localparam logic [3:0] ALUXOR   = 4'd3;
   localparam logic [3:0] ALUMUL   = 4'd4;
   localparam logic [3:0] RNONE    = 4'hF;

   localparam int         MUL_ITERS   = 64 / MUL_BITS_PER_CYCLE;
   localparam logic [6:0] MUL_ITERS_C = 7'(MUL_ITERS);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DONE = 2'd2
   } mul_state_t;

   mul_state_t   state, state_nxt;
   logic         busy;
   logic         mul_req;
   logic         mul_last;
   logic         set_cc;

   logic [63:0]  alu_a, alu_b, alu_res;
   logic [3:0]   alu_fun;
   logic         alu_of;

   logic [127:0] mcand, acc, pp, acc_nxt, prod_signed;
   logic [63:0]  mplier, mplier_nxt;
   logic [63:0]  abs_a, abs_b, mul_res;
   logic [6:0]   count;
   logic         prod_neg, mul_of;
   logic [2:0]   cc;
   logic         cnd;

   assign mul_req = (E_icode_i == IOPQ) && (E_ifun_i == ALUMUL) && (E_stat_i == SAOK);
   assign set_cc  = (E_icode_i == IOPQ) && (m_stat_i == SAOK) &&
                    (W_stat_i == SAOK) && (E_stat_i == SAOK);

   // ALU operand A selection by instruction class
   always_comb begin
      alu_a = '0;
      case (E_icode_i)
         IRRMOVQ, IOPQ:             alu_a = E_valA_i;
         IIRMOVQ, IRMMOVQ, IMRMOVQ: alu_a = E_valC_i;
         ICALL, IPUSHQ:             alu_a = 64'hFFFF_FFFF_FFFF_FFF8;
         IRET, IPOPQ:               alu_a = 64'd8;
         default:                   alu_a = '0;
      endcase
   end

   // ALU operand B selection by instruction class
   always_comb begin
      alu_b = '0;
      case (E_icode_i)
         IRMMOVQ, IMRMOVQ, IOPQ, ICALL, IPUSHQ, IRET, IPOPQ: alu_b = E_valB_i;
         default:                                            alu_b = '0;
      endcase
   end

   assign alu_fun = (E_icode_i == IOPQ) ? E_ifun_i : ALUADD;

   // Single-cycle ALU; unsupported functions (including mul here) yield zero
   always_comb begin
      alu_res = '0;
      alu_of  = 1'b0;
      case (alu_fun)
         ALUADD: begin
            alu_res = alu_b + alu_a;
            alu_of  = (alu_a[63] == alu_b[63]) && (alu_res[63] != alu_a[63]);
         end
         ALUSUB: begin
            alu_res = alu_b - alu_a;
            alu_of  = (alu_a[63] != alu_b[63]) && (alu_res[63] != alu_b[63]);
         end
         ALUAND:  alu_res = alu_b & alu_a;
         ALUXOR:  alu_res = alu_b ^ alu_a;
         default: alu_res = '0;
      endcase
   end

   // Operand magnitudes; |min| = 2^63 still fits as an unsigned 64-bit value
   assign abs_a = E_valA_i[63] ? (~E_valA_i + 64'd1) : E_valA_i;
   assign abs_b = E_valB_i[63] ? (~E_valB_i + 64'd1) : E_valB_i;

   // Partial product for this iteration's multiplier bits
   always_comb begin
      pp = '0;
      for (int i = 0; i < MUL_BITS_PER_CYCLE; i++) begin
         if (mplier[i]) pp = pp + (mcand << i);
      end
   end

   assign acc_nxt    = acc + pp;
   assign mplier_nxt = mplier >> MUL_BITS_PER_CYCLE;

`ifdef MUL_EARLY_EXIT_EN
   // Multiplicand is pre-shifted, so the accumulator is already final once
   // no multiplier bits remain
   assign mul_last = (count == 7'd1) || (mplier_nxt == 64'd0);
`else
   assign mul_last = (count == 7'd1);
`endif

   // Apply the product sign and detect 64-bit signed overflow
   assign prod_signed = prod_neg ? (~acc + 128'd1) : acc;
   assign mul_res     = prod_signed[63:0];
   assign mul_of      = (prod_signed[127:64] != {64{prod_signed[63]}});

   // Multiply FSM state register
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) state <= ST_IDLE;
      else          state <= state_nxt;
   end

   // Multiply FSM next-state and busy decode
   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      case (state)
         ST_IDLE: begin
            if (mul_req) begin
               busy      = 1'b1;
               state_nxt = ST_MUL;
            end
         end
         ST_MUL: begin
            busy = 1'b1;
            if (mul_last) state_nxt = ST_DONE;
         end
         ST_DONE: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Busy is forced low while reset is held so control sees no stall
   assign e_busy_o = busy & rst_n_i;

   // Multiplier datapath: load magnitudes in IDLE, shift-add in MUL
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         mcand    <= '0;
         mplier   <= '0;
         acc      <= '0;
         count    <= '0;
         prod_neg <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (mul_req) begin
                  mcand    <= {64'd0, abs_a};
                  mplier   <= abs_b;
                  acc      <= '0;
                  count    <= MUL_ITERS_C;
                  prod_neg <= E_valA_i[63] ^ E_valB_i[63];
               end
            end
            ST_MUL: begin
               acc    <= acc_nxt;
               mcand  <= mcand << MUL_BITS_PER_CYCLE;
               mplier <= mplier_nxt;
               count  <= count - 7'd1;
            end
            default: ;
         endcase
      end
   end

   // Condition codes: ALU ops update in IDLE, mulq only at its DONE edge
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         cc <= 3'b100;
      end else if (state == ST_DONE) begin
         if (set_cc) cc <= {(mul_res == 64'd0), mul_res[63], mul_of};
      end else if ((state == ST_IDLE) && set_cc && (E_ifun_i != ALUMUL)) begin
         cc <= {(alu_res == 64'd0), alu_res[63], alu_of};
      end
   end

   // Branch / cmov condition from the registered flags {ZF,SF,OF}
   always_comb begin
      cnd = 1'b0;
      case (E_ifun_i)
         4'd0:    cnd = 1'b1;
         4'd1:    cnd = (cc[1] ^ cc[0]) | cc[2];
         4'd2:    cnd = cc[1] ^ cc[0];
         4'd3:    cnd = cc[2];
         4'd4:    cnd = ~cc[2];
         4'd5:    cnd = ~(cc[1] ^ cc[0]);
         4'd6:    cnd = ~(cc[1] ^ cc[0]) & ~cc[2];
         default: cnd = 1'b0;
      endcase
   end

   assign cc_o     = cc;
   assign e_Cnd_o  = cnd;
   assign e_valE_o = (state == ST_DONE) ? mul_res : alu_res;
   assign e_valA_o = E_valA_i;
   assign e_dstM_o = E_dstM_i;
   assign e_dstE_o = ((E_icode_i == IRRMOVQ) && !cnd) ? RNONE : E_dstE_i;

endmodule
`default_nettype wire

// File: tb/tb_execute_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_execute_stage                                              |
// | Purpose  : Self-checking bench for execute_stage: vector table for the   |
// |            single-cycle paths, scoreboarded multiply sequences, reset    |
// |            during a multiply. Honours MUL_EARLY_EXIT_EN if defined.      |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_execute_stage;

   localparam int         MBPC    = 2;
   localparam logic [3:0] SAOK    = 4'd1;
   localparam logic [3:0] SADR    = 4'd2;
   localparam logic [3:0] INOP    = 4'h1;
   localparam logic [3:0] IRRMOVQ = 4'h2;
   localparam logic [3:0] IIRMOVQ = 4'h3;
   localparam logic [3:0] IMRMOVQ = 4'h5;
   localparam logic [3:0] IOPQ    = 4'h6;
   localparam logic [3:0] IJXX    = 4'h7;
   localparam logic [3:0] ICALL   = 4'h8;
   localparam logic [3:0] IPOPQ   = 4'hB;
   localparam logic [63:0] MAXP   = 64'h7FFF_FFFF_FFFF_FFFF;
   localparam logic [63:0] MINN   = 64'h8000_0000_0000_0000;
   localparam logic [63:0] ALL1   = 64'hFFFF_FFFF_FFFF_FFFF;

   logic        clk_i = 1'b0;
   logic        rst_n_i = 1'b0;
   logic [3:0]  E_stat_i, E_icode_i, E_ifun_i, E_dstE_i, E_dstM_i, m_stat_i, W_stat_i;
   logic [63:0] E_valC_i, E_valA_i, E_valB_i;
   logic [63:0] e_valE_o, e_valA_o;
   logic [3:0]  e_dstE_o, e_dstM_o;
   logic        e_Cnd_o, e_busy_o;
   logic [2:0]  cc_o;

   int          checks = 0;
   int          errors = 0;
   logic [2:0]  model_cc;

   always #5 clk_i = ~clk_i;

   execute_stage #(.MUL_BITS_PER_CYCLE(MBPC)) dut (
      .clk_i(clk_i), .rst_n_i(rst_n_i),
      .E_stat_i(E_stat_i), .E_icode_i(E_icode_i), .E_ifun_i(E_ifun_i),
      .E_valC_i(E_valC_i), .E_valA_i(E_valA_i), .E_valB_i(E_valB_i),
      .E_dstE_i(E_dstE_i), .E_dstM_i(E_dstM_i),
      .m_stat_i(m_stat_i), .W_stat_i(W_stat_i),
      .e_valE_o(e_valE_o), .e_valA_o(e_valA_o), .e_dstE_o(e_dstE_o),
      .e_dstM_o(e_dstM_o), .e_Cnd_o(e_Cnd_o), .e_busy_o(e_busy_o), .cc_o(cc_o)
   );

   typedef struct {
      logic [3:0]  stat, icode, ifun;
      logic [63:0] valc, vala, valb;
      logic [3:0]  dste, mstat;
      logic [63:0] exp_vale;
      logic [3:0]  exp_dste;
      logic        chk_cnd, exp_cnd;
      logic [2:0]  exp_cc;
   } vec_t;

   typedef struct {
      logic [63:0] vale;
      logic [2:0]  cc;
      int          busy;
   } exp_t;

   localparam int NV = 20;
   vec_t vecs [0:NV-1];
   exp_t sb [$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [3:0] stat, input logic [3:0] icode, input logic [3:0] ifun,
                        input logic [63:0] valc, input logic [63:0] vala, input logic [63:0] valb,
                        input logic [3:0] dste, input logic [3:0] mstat);
      E_stat_i = stat;  E_icode_i = icode; E_ifun_i = ifun;
      E_valC_i = valc;  E_valA_i = vala;   E_valB_i = valb;
      E_dstE_i = dste;  E_dstM_i = 4'h5;   m_stat_i = mstat; W_stat_i = SAOK;
   endtask

   // Expected busy cycles: IDLE plus the number of MUL iterations
   function automatic int exp_busy(input logic [63:0] b);
      logic [63:0] m;
      int          it;
      m  = b[63] ? (~b + 64'd1) : b;
      it = 64 / MBPC;
`ifdef MUL_EARLY_EXIT_EN
      it = 1;
      while (((m >> (MBPC * it)) != 64'd0) && (it < 64 / MBPC)) it++;
`endif
      return 1 + it;
   endfunction

   task automatic push_mul(input logic [63:0] a, input logic [63:0] b, input logic [3:0] mstat);
      logic signed [127:0] p;
      exp_t e;
      p = $signed({{64{b[63]}}, b}) * $signed({{64{a[63]}}, a});
      e.vale = p[63:0];
      e.cc   = (mstat == SAOK) ? {(p[63:0] == 64'd0), p[63], (p[127:64] != {64{p[63]}})} : model_cc;
      e.busy = exp_busy(b);
      sb.push_back(e);
   endtask

   // Entered just after a rising edge with the mulq on E; leaves just after a rising edge
   task automatic wait_done(input string name);
      int   cnt;
      exp_t e;
      cnt = 0;
      @(negedge clk_i);
      while ((e_busy_o === 1'b1) && (cnt < 200)) begin
         cnt++;
         @(negedge clk_i);
      end
      if (cnt >= 200) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout: busy still high after %0d cycles, required low", name, cnt);
      end
      e = sb.pop_front();
      check({name, "_busy_cycles"}, 64'(cnt), 64'(e.busy));
      check({name, "_valE"}, e_valE_o, e.vale);
      check({name, "_cc_before_done"}, 64'(cc_o), 64'(model_cc));
      @(posedge clk_i); #1;
      drive(SAOK, INOP, 4'd0, 64'd0, 64'd0, 64'd0, 4'hF, SAOK);
      check({name, "_cc"}, 64'(cc_o), 64'(e.cc));
      model_cc = e.cc;
      @(negedge clk_i);
      check({name, "_idle_busy"}, 64'(e_busy_o), 64'd0);
      check({name, "_idle_valE"}, e_valE_o, 64'd0);
      @(posedge clk_i); #1;
   endtask

   task automatic run_mul(input string name, input logic [63:0] a, input logic [63:0] b,
                          input logic [3:0] mstat);
      push_mul(a, b, mstat);
      drive(SAOK, IOPQ, 4'd4, 64'd0, a, b, 4'h3, mstat);
      wait_done(name);
   endtask

   initial begin
      // stat, icode, ifun, valC, valA, valB, dstE, m_stat, valE, dstE, chkCnd, Cnd, cc-after
      vecs[0]  = '{SAOK, IOPQ,    4'd1, 64'd0,     64'd7,      64'd5,     4'h3, SAOK, 64'hFFFF_FFFF_FFFF_FFFE, 4'h3, 1'b0, 1'b0, 3'b010};
      vecs[1]  = '{SAOK, IJXX,    4'd2, 64'h400,   64'd0,      64'd0,     4'hF, SAOK, 64'd0,      4'hF, 1'b1, 1'b1, 3'b010};
      vecs[2]  = '{SAOK, IOPQ,    4'd0, 64'd0,     64'd1,      MAXP,      4'h3, SADR, MINN,       4'h3, 1'b0, 1'b0, 3'b010};
      vecs[3]  = '{SAOK, IOPQ,    4'd0, 64'd0,     64'd1,      MAXP,      4'h3, SAOK, MINN,       4'h3, 1'b0, 1'b0, 3'b011};
      vecs[4]  = '{SAOK, IJXX,    4'd1, 64'd0,     64'd0,      64'd0,     4'hF, SAOK, 64'd0,      4'hF, 1'b1, 1'b0, 3'b011};
      vecs[5]  = '{SAOK, IJXX,    4'd5, 64'd0,     64'd0,      64'd0,     4'hF, SAOK, 64'd0,      4'hF, 1'b1, 1'b1, 3'b011};
      vecs[6]  = '{SAOK, IOPQ,    4'd2, 64'd0,     64'h0F,     64'hF0,    4'h3, SAOK, 64'd0,      4'h3, 1'b0, 1'b0, 3'b100};
      vecs[7]  = '{SAOK, IRRMOVQ, 4'd3, 64'd0,     64'h1234,   64'h999,   4'h2, SAOK, 64'h1234,   4'h2, 1'b1, 1'b1, 3'b100};
      vecs[8]  = '{SAOK, IOPQ,    4'd3, 64'd0,     64'h0F,     64'hFF,    4'h3, SAOK, 64'hF0,     4'h3, 1'b0, 1'b0, 3'b000};
      vecs[9]  = '{SAOK, IRRMOVQ, 4'd3, 64'd0,     64'h1234,   64'h999,   4'h2, SAOK, 64'h1234,   4'hF, 1'b1, 1'b0, 3'b000};
      vecs[10] = '{SAOK, IIRMOVQ, 4'd0, 64'h55,    64'h77,     64'h999,   4'h3, SAOK, 64'h55,     4'h3, 1'b0, 1'b0, 3'b000};
      vecs[11] = '{SAOK, IMRMOVQ, 4'd0, 64'h10,    64'h77,     64'h100,   4'h4, SAOK, 64'h110,    4'h4, 1'b0, 1'b0, 3'b000};
      vecs[12] = '{SAOK, ICALL,   4'd0, 64'h40,    64'h77,     64'h100,   4'h4, SAOK, 64'hF8,     4'h4, 1'b0, 1'b0, 3'b000};
      vecs[13] = '{SAOK, IPOPQ,   4'd0, 64'h40,    64'h77,     64'h100,   4'h4, SAOK, 64'h108,    4'h4, 1'b0, 1'b0, 3'b000};
      vecs[14] = '{SAOK, IOPQ,    4'd5, 64'd0,     64'd3,      64'd4,     4'h3, SAOK, 64'd0,      4'h3, 1'b0, 1'b0, 3'b100};
      vecs[15] = '{SADR, IOPQ,    4'd1, 64'd0,     64'd2,      64'd1,     4'h3, SAOK, ALL1,       4'h3, 1'b0, 1'b0, 3'b100};
      vecs[16] = '{SAOK, IOPQ,    4'd1, 64'd0,     64'd1,      MINN,      4'h3, SAOK, MAXP,       4'h3, 1'b0, 1'b0, 3'b001};
      vecs[17] = '{SAOK, IJXX,    4'd6, 64'd0,     64'd0,      64'd0,     4'hF, SAOK, 64'd0,      4'hF, 1'b1, 1'b0, 3'b001};
      vecs[18] = '{SAOK, IJXX,    4'd4, 64'd0,     64'd0,      64'd0,     4'hF, SAOK, 64'd0,      4'hF, 1'b1, 1'b1, 3'b001};
      vecs[19] = '{SAOK, IRRMOVQ, 4'd0, 64'd0,     64'h9,      64'd0,     4'h2, SAOK, 64'h9,      4'h2, 1'b1, 1'b1, 3'b001};

      drive(SAOK, INOP, 4'd0, 64'd0, 64'd0, 64'd0, 4'hF, SAOK);
      rst_n_i = 1'b0;
      repeat (2) @(posedge clk_i);
      #1 rst_n_i = 1'b1;
      check("reset_cc", 64'(cc_o), 64'b100);
      check("reset_busy", 64'(e_busy_o), 64'd0);
      model_cc = 3'b100;

      for (int i = 0; i < NV; i++) begin
         drive(vecs[i].stat, vecs[i].icode, vecs[i].ifun, vecs[i].valc,
               vecs[i].vala, vecs[i].valb, vecs[i].dste, vecs[i].mstat);
         @(negedge clk_i);
         check($sformatf("vec%0d_valE", i), e_valE_o, vecs[i].exp_vale);
         check($sformatf("vec%0d_dstE", i), 64'(e_dstE_o), 64'(vecs[i].exp_dste));
         check($sformatf("vec%0d_busy", i), 64'(e_busy_o), 64'd0);
         check($sformatf("vec%0d_valA", i), e_valA_o, vecs[i].vala);
         check($sformatf("vec%0d_dstM", i), 64'(e_dstM_o), 64'h5);
         if (vecs[i].chk_cnd)
            check($sformatf("vec%0d_cnd", i), 64'(e_Cnd_o), 64'(vecs[i].exp_cnd));
         @(posedge clk_i); #1;
         check($sformatf("vec%0d_cc", i), 64'(cc_o), 64'(vecs[i].exp_cc));
         model_cc = vecs[i].exp_cc;
      end

      // A mulq with non-AOK status must not start
      drive(SADR, IOPQ, 4'd4, 64'd0, 64'd7, 64'd3, 4'h3, SAOK);
      @(negedge clk_i);
      check("mul_sadr_busy", 64'(e_busy_o), 64'd0);
      @(posedge clk_i); #1;
      check("mul_sadr_cc", 64'(cc_o), 64'(model_cc));

      run_mul("mul_m3x7", 64'd7, -64'sd3, SAOK);

      // Reset in the middle of a multiply, then restart with E held
      drive(SAOK, IOPQ, 4'd4, 64'd0, 64'd7, -64'sd3, 4'h3, SAOK);
      repeat (10) @(negedge clk_i);
      #1 rst_n_i = 1'b0;
      #1;
      check("midreset_busy", 64'(e_busy_o), 64'd0);
      check("midreset_cc", 64'(cc_o), 64'b100);
      model_cc = 3'b100;
      @(posedge clk_i); #1 rst_n_i = 1'b1;
      push_mul(64'd7, -64'sd3, SAOK);
      wait_done("mul_after_reset");

      run_mul("mul_2p40x2p30", 64'd1 << 30, 64'd1 << 40, SAOK);
      run_mul("mul_minxm1", ALL1, MINN, SAOK);
      run_mul("mul_maxxmax", MAXP, MAXP, SAOK);
      run_mul("mul_5x0", 64'd5, 64'd0, SAOK);
      run_mul("mul_m1xm1_sadr", ALL1, ALL1, SADR);
      run_mul("mul_3x5", 64'd5, 64'd3, SAOK);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish, required completion");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
